// File: rtl/random_bank.sv
`default_nettype none
// ============================================================================
//  Module   : random_bank
//  Purpose  : Bank of CHANNELS independent Fibonacci LFSR generators sharing
//             one base seed. Each channel is seeded with a distinct mix of the
//             base seed and stepped through WARMUP discarded steps after every
//             load. In IDLE, every accepted request steps all channels once.
//             One cycle later the new words appear on dataOut, together with a
//             per-channel Bernoulli result (word < threshold) on sample.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous active-high reset
//             seed       - base seed [WIDTH-1:0], sampled in LOAD
//             load_seed  - reseed request, honoured in any state
//             req        - request one new word per channel (when ready)
//             prob       - per-channel threshold, channel i at [i*WIDTH +: WIDTH]
//             ready      - high only in IDLE
//             valid      - one-cycle pulse when new results are presented
//             dataOut    - per-channel random word, same packing as prob
//             sample     - per-channel Bernoulli result
//  Revision : 1.0 - initial release
// ============================================================================
module random_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int WARMUP   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          seed,
  input  logic                      load_seed,
  input  logic                      req,
  input  logic [CHANNELS*WIDTH-1:0] prob,
  output logic                      ready,
  output logic                      valid,
  output logic [CHANNELS*WIDTH-1:0] dataOut,
  output logic [CHANNELS-1:0]       sample
);

  // Maximal-length tap masks, bit n set when bit n feeds the XOR.
  localparam logic [31:0] C_TAPS32 =
      (WIDTH == 8)  ? 32'h0000_00B8 :
      (WIDTH == 16) ? 32'h0000_B400 :
      (WIDTH == 24) ? 32'h00E1_0000 :
                      32'h8020_0003;
  localparam logic [WIDTH-1:0] C_TAPS      = WIDTH'(C_TAPS32);
  localparam logic [31:0]      C_GOLDEN    = 32'h9E37_79B9;
  localparam logic [7:0]       C_WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WARM = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [7:0]                     warm_cnt_q, warm_cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0]            sample_q, sample_d;
  logic                           valid_q, valid_d;

  logic [CHANNELS-1:0][WIDTH-1:0] lfsr_seed;
  logic [CHANNELS-1:0][WIDTH-1:0] lfsr_step;
  logic [CHANNELS-1:0]            sample_new;

  // Per-channel seed derivation, single LFSR step and threshold compare.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] mix;
    assign mix           = seed ^ WIDTH'(32'(i) * C_GOLDEN);
    // A zero seed would lock the LFSR; substitute 1.
    assign lfsr_seed[i]  = (mix == '0) ? WIDTH'(1) : mix;
    assign lfsr_step[i]  = {lfsr_q[i][WIDTH-2:0], ^(lfsr_q[i] & C_TAPS)};
    assign sample_new[i] = (lfsr_step[i] < prob[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      warm_cnt_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sample_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        lfsr_q[i] <= WIDTH'(1);
      end
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sample_q   <= sample_d;
      lfsr_q     <= lfsr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    lfsr_d     = lfsr_q;
    data_d     = data_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;

    if (load_seed) begin
      // Reseed wins over everything, including a same-cycle req.
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          lfsr_d     = lfsr_seed;
          warm_cnt_d = '0;
          state_d    = (WARMUP > 0) ? ST_WARM : ST_IDLE;
        end
        ST_WARM: begin
          lfsr_d     = lfsr_step;
          warm_cnt_d = warm_cnt_q + 8'd1;
          if (warm_cnt_q == C_WARM_LAST) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (req) begin
            lfsr_d   = lfsr_step;
            data_d   = lfsr_step;
            sample_d = sample_new;
            valid_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign valid   = valid_q;
  assign dataOut = data_q;
  assign sample  = sample_q;

endmodule
`default_nettype wire

// File: tb/tb_random_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_bank
//  Purpose  : Self-checking bench for random_bank. A main instance (8-bit,
//             4 channels, 16 warm-up steps) runs against a behavioural model;
//             two small instances pin literal expectations for other widths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_random_bank;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int WU = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic           rst, ld, req;
  logic [W-1:0]   seed;
  logic [C*W-1:0] prob;
  logic           rdy, vld;
  logic [C*W-1:0] dout;
  logic [C-1:0]   smp;

  random_bank #(.WIDTH(W), .CHANNELS(C), .WARMUP(WU)) dut (
    .clk(clk), .reset(rst), .seed(seed), .load_seed(ld), .req(req), .prob(prob),
    .ready(rdy), .valid(vld), .dataOut(dout), .sample(smp)
  );

  // 8-bit, single channel, no warm-up
  logic       rst1, ld1, req1, rdy1, vld1;
  logic [7:0] seed1, prob1, dout1;
  logic [0:0] smp1;

  random_bank #(.WIDTH(8), .CHANNELS(1), .WARMUP(0)) dut1 (
    .clk(clk), .reset(rst1), .seed(seed1), .load_seed(ld1), .req(req1), .prob(prob1),
    .ready(rdy1), .valid(vld1), .dataOut(dout1), .sample(smp1)
  );

  // 16-bit, two channels, no warm-up
  logic        rst2, ld2, req2, rdy2, vld2;
  logic [15:0] seed2;
  logic [31:0] prob2, dout2;
  logic [1:0]  smp2;

  random_bank #(.WIDTH(16), .CHANNELS(2), .WARMUP(0)) dut2 (
    .clk(clk), .reset(rst2), .seed(seed2), .load_seed(ld2), .req(req2), .prob(prob2),
    .ready(rdy2), .valid(vld2), .dataOut(dout2), .sample(smp2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic int unsigned wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int unsigned lstep(input int unsigned s, input int w);
    bit fb;
    case (w)
      8:       fb = s[7]  ^ s[5]  ^ s[4]  ^ s[3];
      16:      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      24:      fb = s[23] ^ s[22] ^ s[21] ^ s[16];
      default: fb = s[31] ^ s[21] ^ s[1]  ^ s[0];
    endcase
    return ((s << 1) | {31'd0, fb}) & wmask(w);
  endfunction

  function automatic int unsigned chseed(input int unsigned sd, input int unsigned i, input int w);
    int unsigned x;
    x = (sd ^ (i * 32'h9E37_79B9)) & wmask(w);
    return (x == 0) ? 32'd1 : x;
  endfunction

  function automatic int unsigned advance(input int unsigned s, input int n, input int w);
    int unsigned r;
    r = s;
    for (int k = 0; k < n; k++) r = lstep(r, w);
    return r;
  endfunction

  // ---------------- behavioural model of main instance ----------------
  // m_wait counts cycles until ready: WU+1 means "seeds load on next edge".
  int unsigned m_st[C];
  int unsigned m_dout[C];
  bit          m_smp[C];
  bit          m_vld;
  int          m_wait;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_wait = WU + 1;
      m_vld  = 1'b0;
      for (int i = 0; i < C; i++) begin
        m_dout[i] = 0;
        m_smp[i]  = 1'b0;
      end
    end else begin
      m_vld = 1'b0;
      if (ld) begin
        m_wait = WU + 1;
      end else if (m_wait > 0) begin
        if (m_wait == WU + 1)
          for (int i = 0; i < C; i++) m_st[i] = advance(chseed(32'(seed), i, W), WU, W);
        m_wait--;
      end else if (req) begin
        for (int i = 0; i < C; i++) begin
          m_st[i]   = lstep(m_st[i], W);
          m_dout[i] = m_st[i];
          m_smp[i]  = (m_st[i] < 32'(prob[i*W +: W]));
        end
        m_vld = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [C*W-1:0] ed;
    logic [C-1:0]   es;
    if (cmp_en) begin
      for (int i = 0; i < C; i++) begin
        ed[i*W +: W] = m_dout[i][W-1:0];
        es[i]        = m_smp[i];
      end
      chk("ready", rdy, (m_wait == 0));
      chk("valid", vld, m_vld);
      chk("dataOut", dout, ed);
      chk("sample", smp, es);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          cnt, nv, zeros, nvld, bad_rdy, bad_smp, got, guard, s0, s2, s3bad, eq, mism;
    logic [7:0]  first, last;
    int unsigned a0, a1;

    rst = 1'b1; ld = 1'b0; req = 1'b0; seed = '0; prob = '0;
    rst1 = 1'b1; ld1 = 1'b0; req1 = 1'b0; seed1 = 8'hA5; prob1 = '0;
    rst2 = 1'b1; ld2 = 1'b0; req2 = 1'b0; seed2 = 16'h0001; prob2 = '0;

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;

    // Single channel, seed A5, one request
    rst1 = 1'b0;
    @(negedge clk);
    chk("d1_ready_idle", rdy1, 1);
    chk("d1_no_valid", vld1, 0);
    req1 = 1'b1;
    @(negedge clk);
    chk("d1_valid", vld1, 1);
    chk("d1_word_from_A5", dout1, 8'h4A);
    chk("d1_ready_held", rdy1, 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("d1_valid_drop", vld1, 0);
    chk("d1_word_hold", dout1, 8'h4A);

    // Zero seed substitution and full period
    seed1 = 8'h00; ld1 = 1'b1;
    @(negedge clk);
    ld1 = 1'b0;
    chk("d1_load_not_ready", rdy1, 0);
    @(negedge clk);
    chk("d1_ready_after_load", rdy1, 1);
    req1 = 1'b1;
    zeros = 0; nvld = 0; bad_rdy = 0; bad_smp = 0; first = '0; last = '0;
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      if (k == 1) first = dout1;
      if (dout1 == 8'h00) zeros++;
      if (vld1) nvld++;
      if (!rdy1) bad_rdy++;
      if (smp1 != 1'b0) bad_smp++;
      last = dout1;
    end
    req1 = 1'b0;
    chk("d1_first_word", first, 8'h02);
    chk("d1_period_return", last, 8'h01);
    chk("d1_zero_words", zeros, 0);
    chk("d1_valid_count", nvld, 255);
    chk("d1_ready_drops", bad_rdy, 0);
    chk("d1_sample_prob0", bad_smp, 0);

    // 16-bit two-channel seeding and channel independence
    chk("model_seed_ch1", chseed(32'h0001, 1, 16), 32'h79B8);
    rst2 = 1'b0;
    @(negedge clk);
    chk("d2_ready", rdy2, 1);
    req2 = 1'b1;
    a0 = chseed(32'h0001, 0, 16);
    a1 = chseed(32'h0001, 1, 16);
    eq = 0; mism = 0; bad_smp = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      a0 = lstep(a0, 16);
      a1 = lstep(a1, 16);
      if (k == 1) begin
        chk("d2_ch0_first", dout2[15:0], 16'h0002);
        chk("d2_ch1_first", dout2[31:16], 16'hF370);
      end
      if (!vld2 || dout2 !== {a1[15:0], a0[15:0]}) mism++;
      if (dout2[15:0] == dout2[31:16]) eq++;
      if (smp2 != 2'b00) bad_smp++;
    end
    req2 = 1'b0;
    chk("d2_model_mismatches", mism, 0);
    chk("d2_equal_words", eq, 0);
    chk("d2_sample_prob0", bad_smp, 0);

    // Main: req/load_seed together with reset
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = 1'b1; ld = 1'b1; seed = 8'($urandom);
    end
    @(negedge clk);
    chk("main_reset_valid", vld, 0);
    chk("main_reset_data", dout, 0);
    chk("main_reset_sample", smp, 0);
    chk("main_reset_ready", rdy, 0);
    seed = 8'h3C; rst = 1'b0; ld = 1'b0; req = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      if (!rdy) cnt++;
    end while (!rdy && cnt < 100);
    chk("main_warm_after_reset", cnt, WU);

    // Reseed: 1 LOAD + WU WARM cycles without ready, requests ignored
    req = 1'b0;
    repeat (2) @(negedge clk);
    ld = 1'b1; req = 1'b1; cnt = 0; nv = 0;
    do begin
      @(negedge clk);
      ld = 1'b0;
      if (!rdy) cnt++;
      if (vld) nv++;
    end while (!rdy && cnt < 100);
    req = 1'b0;
    chk("main_reseed_busy", cnt, WU + 1);
    chk("main_reseed_valids", nv, 0);

    // Threshold extremes and mid-rate
    @(negedge clk);
    prob = {8'hFF, 8'h80, 8'h01, 8'h00};
    req = 1'b1;
    got = 0; guard = 0; s0 = 0; s2 = 0; s3bad = 0;
    while (got < 1000 && guard < 1200) begin
      @(negedge clk);
      guard++;
      if (vld) begin
        got++;
        if (smp[0]) s0++;
        if (smp[2]) s2++;
        if (smp[3] == (dout[31:24] == 8'hFF)) s3bad++;
      end
    end
    chk("rate_valid_count", got, 1000);
    chk("ch0_prob0_ones", s0, 0);
    chk("ch3_probFF_errors", s3bad, 0);
    chk("ch2_rate_in_band", (s2 >= 450 && s2 <= 550), 1);

    // Randomized traffic with occasional reseed and reset
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      rst = (($urandom % 300) == 0);
      ld  = (($urandom % 80) == 0);
      req = (($urandom % 4) != 0);
      if (($urandom % 8) == 0) seed = 8'($urandom);
      if (($urandom % 16) == 0)
        for (int i = 0; i < C; i++)
          case ($urandom % 4)
            0:       prob[i*W +: W] = 8'h00;
            1:       prob[i*W +: W] = 8'hFF;
            default: prob[i*W +: W] = 8'($urandom);
          endcase
    end
    rst = 1'b0; ld = 1'b0; req = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/random_bank.md
RANDOM_BANK -- requirements
Module: random_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning LFSR and output word width; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of independent generators; legal range 1..16.
REQ-003 SHALL have parameter WARMUP, default 16, meaning discarded steps after every seed load; legal range 0..255.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port seed  input  WIDTH  base seed, sampled at reset and at load_seed.
REQ-007 SHALL have port load_seed  input  1  reseed request; honoured in any state.
REQ-008 SHALL have port req  input  1  request for one new random word per channel.
REQ-009 SHALL have port prob  input  CHANNELS*WIDTH  per-channel threshold; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port ready  output  1  high when req will be accepted.
REQ-011 SHALL have port valid  output  1  high for exactly one cycle when new results are presented.
REQ-012 SHALL have port dataOut  output  CHANNELS*WIDTH  per-channel random word, same packing as prob.
REQ-013 SHALL have port sample  output  CHANNELS  per-channel Bernoulli result.

Function
REQ-014 SHALL implement per channel a Fibonacci LFSR: shift left by one, new bit0 = XOR of the tapped bits.
REQ-015 SHALL use maximal-length taps by WIDTH: 8 -> bits 7,5,4,3; 16 -> 15,13,12,10; 24 -> 23,22,21,16; 32 -> 31,21,1,0.
REQ-016 SHALL derive channel i seed as seed XOR (i * 32'h9E3779B9 truncated to WIDTH); a result of zero SHALL be replaced by 1.
REQ-017 SHALL never hold an all-zero LFSR state.
REQ-018 SHALL use a three-state FSM: LOAD, WARM, IDLE.
REQ-019 LOAD: load all channel seeds in one cycle, clear warm counter; go to WARM if WARMUP>0, else IDLE.
REQ-020 WARM: step all LFSRs every cycle, increment counter; go to IDLE after exactly WARMUP steps.
REQ-021 SHALL drive ready=1 only in IDLE.
REQ-022 IDLE with req=1: step all LFSRs once and capture prob; the next cycle SHALL assert valid=1 with dataOut = stepped states.
REQ-023 SHALL compute sample[i] = (dataOut_i < prob_i), unsigned, from the prob captured with the accepted req.
REQ-024 SHALL hold req back-to-back at full rate: req held high in IDLE gives one new word per cycle and valid high every cycle.
REQ-025 SHALL hold dataOut and sample stable between valid pulses; valid=0 otherwise.
REQ-026 SHALL ignore req when ready=0; no LFSR step and no valid result.
REQ-027 load_seed=1 SHALL go to LOAD on the next edge from any state; a same-cycle req SHALL be dropped; load_seed wins.
REQ-028 SHALL let prob=0 give sample=0 always; prob = all-ones gives sample=1 except when dataOut is all-ones.

Reset
REQ-029 reset SHALL take priority over load_seed and req.
REQ-030 reset SHALL enter LOAD with valid=0, ready=0, dataOut=0, sample=0.
REQ-031 On the first edge after reset deasserts, the block SHALL load seeds from the current seed input as in REQ-019.
REQ-032 reset asserted mid-WARM or during a valid cycle SHALL abort the operation; no valid pulse SHALL follow.

Verification
REQ-033 WIDTH=8, CHANNELS=1, WARMUP=0, seed=8'hA5, one req -> valid one cycle later, dataOut=8'h4A, ready high throughout IDLE.
REQ-034 Same configuration, seed=8'h00 -> state 8'h01; first req -> dataOut=8'h02; 255 consecutive reqs -> state returns to 8'h01, no zero observed.
REQ-035 WARMUP=16, load_seed pulse -> ready low for 17 cycles (1 LOAD + 16 WARM); req during that time -> no valid.
REQ-036 CHANNELS=4, prob = {8'hFF, 8'h80, 8'h01, 8'h00}, 1000 reqs -> channel 0 sample never 1; channel 3 sample 0 only when dataOut=8'hFF; channel 2 rate about 50% (+/-5%).
REQ-037 reset asserted during WARM, and req/load_seed asserted together with reset -> valid=0, outputs zero; sequence restarts from the new seed.
REQ-038 WIDTH=16, seed=16'h0001, CHANNELS=2 -> channel 1 seed = 16'h79B8; the two channels never produce equal words for the first 1000 steps.
